jar_pi_sequencer: RTL and testbench
===================================

Name: jar_pi_sequencer

Overview:
- Upstream stage of the pi-digit lookup. Produces the 8-bit digit index that the lookup decodes into a hex digit for the 7-segment driver.
- Walks the index at a pin-selectable rate, forward or backward, with run, pause and single-step control.
- All control inputs come from pins and are treated as asynchronous.

Parameters:
- PRESCALE_W, 12, width of the tick prescaler. Must be ≥10.
- IDX_W, 8, width of the digit index.
- LAST_IDX, 255, highest index before wrap. Must be < 2^IDX_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  level: 1 = auto-advance, 0 = pause
- step  in  1  rising edge advances the index once while paused
- dir  in  1  0 = increment, 1 = decrement
- clear  in  1  level: force index to 0 and return to IDLE
- rate  in  2  tick period select
- idx  out  IDX_W  current digit index (feeds the lookup)
- adv  out  1  one-cycle pulse in the cycle idx changes
- wrap  out  1  one-cycle pulse when idx wraps (coincides with adv)
- blank  out  1  display blank request (see Optional Feature)

Behaviour:
- Reset (async, active-high) values:
  - idx=0, adv=0, wrap=0, blank=0
  - state=IDLE, prescaler=0
  - all synchronizer and edge flops = 0
- Input synchronization:
  - run, step, dir and clear each pass through a 2-flop synchronizer.
  - A pin change is visible to the FSM on the 2nd rising clk edge after it.
  - step has a 3rd flop for edge detection: rising edge = sync_step & ~step_d.
- Tick generation:
  - period = 2^(PRESCALE_W − 3·rate). Defaults: rate 0/1/2/3 → 4096/512/64/8 cycles.
  - The prescaler counts only in RUN and clears to 0 on every entry to RUN.
  - tick fires when prescaler == period−1; the prescaler wraps to 0 on the same edge.
  - A rate change mid-run takes effect from the next comparison. No prescaler reset.
- FSM states:
  - IDLE: idx held at 0. sync_run=1 → RUN.
  - RUN: on tick, advance. sync_run=0 → PAUSE; idx is held and the prescaler is frozen.
  - PAUSE: step edge → advance once and stay in PAUSE. sync_run=1 → RUN (prescaler cleared).
  - sync_clear=1 in any state: next edge sets idx=0, state=IDLE, adv=0, wrap=0. clear has priority over tick, step and run.
- Advance:
  - dir is sampled on the advance edge. Increment is idx+1; decrement is idx−1.
  - Wrap cases:
    - increment from LAST_IDX → 0, with wrap=1
    - decrement from 0 → LAST_IDX, with wrap=1
  - adv and wrap are registered and high for exactly the cycle in which the new idx is first visible.
- Latency:
  - First advance occurs exactly `period` cycles after the edge that enters RUN.
  - Subsequent advances occur every `period` cycles.
- Step edge while in RUN or IDLE: ignored, not queued.
- Step edge and run rising simultaneously in PAUSE: the FSM goes to RUN and the step is dropped.
- clear released: stays in IDLE while sync_run=0. If sync_run=1, enters RUN on the edge after sync_clear falls.

Optional Feature:
- Macro: JAR_PI_SEQ_BLANK_EN.
- Defined:
  - In RUN, blank=1 for the first period/4 cycles after each advance, so repeated digits are visibly separated.
  - In PAUSE, a step asserts blank for exactly 1 cycle, starting with the adv cycle.
  - blank=0 in IDLE.
  - blank is registered, and cleared by rst and clear.
- Undefined: blank tied to constant 0 and no extra logic is present.

Test Plan:
- Reset and IDLE: assert rst mid-run → idx=0, adv=0, wrap=0 immediately (async). Release rst with run=0 for 100 cycles → idx stays 0, no adv.
- Forward run: rate=3, dir=0, raise run → first adv exactly 8 cycles after RUN entry, then every 8 cycles; idx goes 1,2,3…
- Wrap both ways: run forward to idx=255 → next advance gives idx=0 with wrap=1 for 1 cycle. Then dir=1 → idx=255 with wrap=1.
- Pause and step: run=0 at idx=5, then 3 step pulses → idx=8 and 3 adv pulses. Holding step high → only one advance. Step during RUN → no extra advance.
- Clear priority: assert clear in the same cycle a tick is due at idx=40 → idx=0, no adv, state IDLE. Release clear with run=1 → RUN resumes and first adv arrives 8 cycles later.
- Blank (macro on): rate=3 → blank high for 2 cycles starting at each adv. Step in PAUSE → 1-cycle blank. Macro off → blank constant 0 throughout.

Source files
------------

// File: rtl/jar_pi_sequencer.sv
// jar_pi_sequencer: walks the 8-bit pi-digit index feeding the hex lookup.
// Pin-level controls (run, step, dir, clear) are synchronized, then a small
// IDLE/RUN/PAUSE FSM advances the index on prescaler ticks or single steps.
// Optional build macro: JAR_PI_SEQ_BLANK_EN enables the display-blank pulse
// after each advance; when undefined, blank is tied to 0.
module jar_pi_sequencer #(
   parameter int PRESCALE_W = 12,
   parameter int IDX_W      = 8,
   parameter int LAST_IDX   = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             step,
   input  logic             dir,
   input  logic             clear,
   input  logic [1:0]       rate,
   output logic [IDX_W-1:0] idx,
   output logic             adv,
   output logic             wrap,
   output logic             blank
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

   logic [1:0]            run_sync;
   logic [1:0]            dir_sync;
   logic [1:0]            clear_sync;
   logic [2:0]            step_sync;   // [2] is the edge-detect delay flop
   logic                  sync_run;
   logic                  sync_dir;
   logic                  sync_clear;
   logic                  step_edge;

   logic [1:0]            state;
   logic [PRESCALE_W-1:0] presc;
   logic [PRESCALE_W-1:0] period_m1;
   logic                  tick;
   logic                  run_adv;
   logic                  step_adv;
   logic [IDX_W-1:0]      next_idx;
   logic                  next_wrap;

   // Two-flop synchronizers for all pin inputs, plus a third flop on step.
   // NOTE: every pin goes through two flops before any logic looks at it; a
   // single flop could hand the FSM a metastable value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_sync   <= '0;
         dir_sync   <= '0;
         clear_sync <= '0;
         step_sync  <= '0;
      end else begin
         run_sync   <= {run_sync[0], run};
         dir_sync   <= {dir_sync[0], dir};
         clear_sync <= {clear_sync[0], clear};
         step_sync  <= {step_sync[1:0], step};
      end
   end

   assign sync_run   = run_sync[1];
   assign sync_dir   = dir_sync[1];
   assign sync_clear = clear_sync[1];
   assign step_edge  = step_sync[1] & ~step_sync[2];

   // Tick period minus one for the selected rate: 2^(PRESCALE_W - 3*rate) - 1.
   always_comb begin
      case (rate)
         2'd0:    period_m1 = PRESCALE_W'((1 << PRESCALE_W) - 1);
         2'd1:    period_m1 = PRESCALE_W'((1 << (PRESCALE_W - 3)) - 1);
         2'd2:    period_m1 = PRESCALE_W'((1 << (PRESCALE_W - 6)) - 1);
         default: period_m1 = PRESCALE_W'((1 << (PRESCALE_W - 9)) - 1);
      endcase
   end

   assign tick     = (presc == period_m1);
   assign run_adv  = !sync_clear && (state == ST_RUN) && sync_run && tick;
   assign step_adv = !sync_clear && (state == ST_PAUSE) && !sync_run && step_edge;

   // Next index in the sampled direction, wrapping at 0 and LAST_IDX.
   // NOTE: both outputs get a default first so no path leaves them unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      next_idx  = idx + 1'b1;
      next_wrap = 1'b0;
      if (sync_dir) begin
         if (idx == '0) begin
            next_idx  = LAST;
            next_wrap = 1'b1;
         end else begin
            next_idx = idx - 1'b1;
         end
      end else if (idx == LAST) begin
         next_idx  = '0;
         next_wrap = 1'b1;
      end
   end

   // Sequencer FSM, prescaler and registered index/adv/wrap.
   // NOTE: state is updated with non-blocking assignments so every flop sees
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         presc <= '0;
         idx   <= '0;
         adv   <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         adv  <= 1'b0;
         wrap <= 1'b0;
         if (sync_clear) begin
            state <= ST_IDLE;
            presc <= '0;
            idx   <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  idx <= '0;
                  if (sync_run) begin
                     state <= ST_RUN;
                     presc <= '0;
                  end
               end
               ST_RUN: begin
                  if (!sync_run) begin
                     state <= ST_PAUSE;
                  end else if (tick) begin
                     presc <= '0;
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
               ST_PAUSE: begin
                  if (sync_run) begin
                     state <= ST_RUN;
                     presc <= '0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
            if (run_adv || step_adv) begin
               idx  <= next_idx;
               adv  <= 1'b1;
               wrap <= next_wrap;
            end
         end
      end
   end

`ifdef JAR_PI_SEQ_BLANK_EN
   logic [PRESCALE_W-1:0] blank_cnt;   // blank cycles still owed after this one

   // Blank for period/4 cycles after a run advance, one cycle after a step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank     <= 1'b0;
         blank_cnt <= '0;
      end else if (sync_clear || (state == ST_IDLE)) begin
         blank     <= 1'b0;
         blank_cnt <= '0;
      end else if (run_adv) begin
         // period/4 - 1 equals (period-1) >> 2 for the power-of-two periods
         blank     <= (period_m1 >= PRESCALE_W'(3));
         blank_cnt <= (period_m1 >= PRESCALE_W'(3)) ? (period_m1 >> 2) : '0;
      end else if (step_adv) begin
         blank     <= 1'b1;
         blank_cnt <= '0;
      end else if (blank_cnt != '0) begin
         blank_cnt <= blank_cnt - 1'b1;
      end else begin
         blank <= 1'b0;
      end
   end
`else
   assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_jar_pi_sequencer.sv
// tb_jar_pi_sequencer: directed scenarios plus randomized pin activity, all
// compared every cycle against a behavioural model of the sequencer.
// Build with JAR_PI_SEQ_BLANK_EN defined to also expect the blank pulses.
`timescale 1ns/1ps
module tb_jar_pi_sequencer;

   localparam int PW   = 12;
   localparam int IW   = 8;
   localparam int LAST = 255;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          run   = 1'b0;
   logic          step  = 1'b0;
   logic          dir   = 1'b0;
   logic          clear = 1'b0;
   logic [1:0]    rate  = 2'd0;
   logic [IW-1:0] idx;
   logic          adv;
   logic          wrap;
   logic          blank;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Behavioural model: mode 0 = idle, 1 = running, 2 = paused.
   int m_mode;
   int m_idx;
   int m_elapsed;      // cycles counted since run entry or last advance
   int m_blank_left;   // cycles of blank still visible, including this one
   bit m_adv;
   bit m_wrap;
   bit h_run[3];       // pin history: [0] previous edge, [1] two edges ago ...
   bit h_dir[3];
   bit h_clr[3];
   bit h_step[3];

   always #5 clk = ~clk;

   jar_pi_sequencer #(.PRESCALE_W(PW), .IDX_W(IW), .LAST_IDX(LAST)) dut (
      .clk   (clk),
      .rst   (rst),
      .run   (run),
      .step  (step),
      .dir   (dir),
      .clear (clear),
      .rate  (rate),
      .idx   (idx),
      .adv   (adv),
      .wrap  (wrap),
      .blank (blank)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int exp_blank();
`ifdef JAR_PI_SEQ_BLANK_EN
      return (m_blank_left > 0) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_mode = 0; m_idx = 0; m_elapsed = 0; m_blank_left = 0;
      m_adv = 1'b0; m_wrap = 1'b0;
      for (int i = 0; i < 3; i++) begin
         h_run[i] = 1'b0; h_dir[i] = 1'b0; h_clr[i] = 1'b0; h_step[i] = 1'b0;
      end
   endtask

   task automatic model_advance(input bit down);
      if (down) m_idx = (m_idx + LAST) % (LAST + 1);
      else      m_idx = (m_idx + 1) % (LAST + 1);
      m_adv  = 1'b1;
      m_wrap = down ? (m_idx == LAST) : (m_idx == 0);
   endtask

   // One rising edge of the model; pins seen by the control logic are the
   // ones sampled two edges earlier.
   task automatic model_step();
      bit s_run, s_dir, s_clr, s_edge;
      int per;
      if (rst) begin
         model_reset();
         return;
      end
      s_run  = h_run[1];
      s_dir  = h_dir[1];
      s_clr  = h_clr[1];
      s_edge = h_step[1] & ~h_step[2];
      per    = 1 << (PW - 3 * int'(rate));
      m_adv  = 1'b0;
      m_wrap = 1'b0;
      if (m_blank_left > 0) m_blank_left--;
      if (s_clr) begin
         m_mode = 0; m_idx = 0; m_elapsed = 0; m_blank_left = 0;
      end else if (m_mode == 0) begin
         if (s_run) begin m_mode = 1; m_elapsed = 0; end
      end else if (m_mode == 1) begin
         if (!s_run) m_mode = 2;
         else if (m_elapsed == per - 1) begin
            model_advance(s_dir);
            m_elapsed    = 0;
            m_blank_left = per / 4;
         end else m_elapsed = (m_elapsed + 1) % (1 << PW);
      end else begin
         if (s_run) begin m_mode = 1; m_elapsed = 0; end
         else if (s_edge) begin
            model_advance(s_dir);
            m_blank_left = 1;
         end
      end
      h_run[2] = h_run[1];   h_run[1] = h_run[0];   h_run[0] = run;
      h_dir[2] = h_dir[1];   h_dir[1] = h_dir[0];   h_dir[0] = dir;
      h_clr[2] = h_clr[1];   h_clr[1] = h_clr[0];   h_clr[0] = clear;
      h_step[2] = h_step[1]; h_step[1] = h_step[0]; h_step[0] = step;
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("idx", idx, m_idx);
         check("adv", adv, m_adv);
         check("wrap", wrap, m_wrap);
         check("blank", blank, exp_blank());
      end
   end

   task automatic tick_cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic wait_adv(input int limit, output int n);
      n = 0;
      do begin
         tick_cyc();
         n++;
      end while (adv !== 1'b1 && n < limit);
      check("adv_within_budget", adv, 1);
   endtask

   task automatic count_cycles(input int cycles, inout int cnt);
      for (int i = 0; i < cycles; i++) begin
         tick_cyc();
         if (adv === 1'b1) cnt++;
      end
   endtask

   initial begin
      int n;
      int cnt;
      model_reset();
      repeat (3) tick_cyc();
      rst    = 1'b0;
      chk_en = 1'b1;
      check("reset_idx", idx, 0);
      check("reset_adv", adv, 0);
      check("reset_wrap", wrap, 0);
      check("reset_blank", blank, 0);

      // Idle with run low: nothing moves.
      cnt = 0;
      count_cycles(100, cnt);
      check("idle_adv_count", cnt, 0);
      check("idle_idx", idx, 0);

      // Forward run at rate 3: run pin -> 2 sync edges -> RUN entry -> 8 cycles.
      rate = 2'd3; dir = 1'b0; run = 1'b1;
      wait_adv(40, n);
      check("first_adv_latency", n, 11);
      check("first_idx", idx, 1);
      wait_adv(20, n);
      check("second_adv_spacing", n, 8);
      check("second_idx", idx, 2);
`ifdef JAR_PI_SEQ_BLANK_EN
      check("blank_adv_cycle", blank, 1);
      tick_cyc();
      check("blank_second_cycle", blank, 1);
      tick_cyc();
      check("blank_third_cycle", blank, 0);
`else
      check("blank_off_adv_cycle", blank, 0);
      repeat (2) tick_cyc();
`endif
      wait_adv(20, n);
      check("third_adv_spacing", n, 6);
      check("third_idx", idx, 3);

      // Forward wrap 255 -> 0, then backward wrap 0 -> 255.
      for (int i = 0; i < 300 && idx != 8'd255; i++) wait_adv(20, n);
      wait_adv(20, n);
      check("fwd_wrap_idx", idx, 0);
      check("fwd_wrap_flag", wrap, 1);
      tick_cyc();
      check("fwd_wrap_one_cycle", wrap, 0);
      dir = 1'b1;
      wait_adv(20, n);
      check("bwd_wrap_idx", idx, 255);
      check("bwd_wrap_flag", wrap, 1);

      // Clear, then run forward to 5 and pause.
      clear = 1'b1;
      repeat (4) tick_cyc();
      check("clear_idx", idx, 0);
      dir = 1'b0; clear = 1'b0;
      for (int i = 0; i < 20 && idx != 8'd5; i++) wait_adv(20, n);
      run = 1'b0;
      cnt = 0;
      count_cycles(12, cnt);
      check("pause_holds_idx", idx, 5);
      check("pause_no_adv", cnt, 0);

      // Three step pulses -> three advances.
      cnt = 0;
      for (int p = 0; p < 3; p++) begin
         step = 1'b1; count_cycles(2, cnt);
         step = 1'b0; count_cycles(4, cnt);
      end
      check("step_pulse_advs", cnt, 3);
      check("step_pulse_idx", idx, 8);

      // Step held high -> only one advance.
      cnt = 0;
      step = 1'b1; count_cycles(20, cnt);
      step = 1'b0; count_cycles(4, cnt);
      check("step_held_advs", cnt, 1);
      check("step_held_idx", idx, 9);

      // Step during RUN is ignored.
      run = 1'b1;
      wait_adv(40, n);
      cnt = 0;
      step = 1'b1; count_cycles(2, cnt);
      step = 1'b0; count_cycles(5, cnt);
      check("run_step_ignored", cnt, 0);
      tick_cyc();
      check("run_regular_adv", adv, 1);

      // Clear arriving on the same edge as a due tick at idx 40.
      for (int i = 0; i < 60 && idx != 8'd40; i++) wait_adv(20, n);
      check("reached_idx_40", idx, 40);
      repeat (5) tick_cyc();
      clear = 1'b1;
      repeat (3) tick_cyc();
      check("clear_prio_idx", idx, 0);
      check("clear_prio_adv", adv, 0);
      tick_cyc();
      clear = 1'b0;
      wait_adv(40, n);
      check("post_clear_latency", n, 11);
      check("post_clear_idx", idx, 1);

      // Randomized pin activity.
      for (int s = 0; s < 60; s++) begin
         int len;
         rate  = ($urandom % 5 == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
         run   = ($urandom % 4) != 0;
         dir   = $urandom % 2;
         clear = ($urandom % 10) == 0;
         len   = $urandom_range(1, 80);
         for (int c = 0; c < len; c++) begin
            step = ($urandom % 3) == 0;
            tick_cyc();
         end
      end

      // Asynchronous reset in the middle of a run.
      clear = 1'b0; step = 1'b0; rate = 2'd3; run = 1'b1; dir = 1'b0;
      repeat (4) tick_cyc();
      wait_adv(40, n);
      wait_adv(20, n);
      #2 rst = 1'b1;
      #1;
      check("async_rst_idx", idx, 0);
      check("async_rst_adv", adv, 0);
      check("async_rst_wrap", wrap, 0);
      run = 1'b0;
      repeat (3) tick_cyc();
      rst = 1'b0;
      cnt = 0;
      count_cycles(100, cnt);
      check("post_rst_adv_count", cnt, 0);
      check("post_rst_idx", idx, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
